// File: rtl/ucode_loader.sv
// Control-store loader: receives byte-stream load packets, verifies the checksum
// and commits the buffered entries into the microcode store or a dispatch table.
module ucode_loader #(
    parameter int unsigned MAX_ENTRIES = 16,
    parameter int unsigned UCODE_DEPTH = 16,
    parameter int unsigned DISP_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in_byte,
    output logic       in_ready,
    output logic       wr_en,
    output logic [1:0] wr_sel,
    output logic [3:0] wr_addr,
    output logic [3:0] wr_data,
    output logic       seq_hold,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        StIdle, StAddr, StData, StCsum, StCommit, StResult
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic [3:0] start_q, start_d;
    logic [3:0] last_q, last_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] csum_q, csum_d;
    logic       err_flag_q, err_flag_d;
    logic [3:0] buf_q [MAX_ENTRIES];
    logic       buf_we;
    logic       accept;
    logic [5:0] disp_end;
    logic [4:0] addr_sum;

    logic       wr_en_d, seq_hold_d, done_d, err_d;
    logic [1:0] wr_sel_d;
    logic [3:0] wr_addr_d, wr_data_d;

    always_comb begin
        in_ready = !reset && (state_q == StIdle || state_q == StAddr ||
                              state_q == StData || state_q == StCsum);
    end

    assign accept   = in_valid && in_ready;
    // One past the last dispatch entry the packet would touch.
    assign disp_end = {2'b00, in_byte[3:0]} + {2'b00, last_q} + 6'd1;

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        start_d    = start_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        csum_d     = csum_q;
        err_flag_d = err_flag_q;
        buf_we     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    sel_d      = in_byte[7:6];
                    last_d     = in_byte[3:0];
                    csum_d     = in_byte;
                    err_flag_d = (in_byte[7:6] == 2'b11) || (in_byte[5:4] != 2'b00);
                    state_d    = StAddr;
                end
            end
            StAddr: begin
                if (accept) begin
                    start_d = in_byte[3:0];
                    csum_d  = csum_q ^ in_byte;
                    cnt_d   = '0;
                    if (in_byte[7:4] != 4'h0 ||
                        (sel_q != 2'b00 && disp_end > 6'(DISP_DEPTH))) begin
                        err_flag_d = 1'b1;
                    end
                    state_d = StData;
                end
            end
            StData: begin
                if (accept) begin
                    buf_we = 1'b1;
                    csum_d = csum_q ^ in_byte;
                    if (in_byte[7:4] != 4'h0 || (sel_q == 2'b00 && in_byte[3])) begin
                        err_flag_d = 1'b1;
                    end
                    if (cnt_q == last_q) begin
                        cnt_d   = '0;
                        state_d = StCsum;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            StCsum: begin
                if (accept) begin
                    cnt_d = '0;
                    if (err_flag_q || csum_q != in_byte) begin
                        err_flag_d = 1'b1;
                        state_d    = StResult;
                    end else begin
                        state_d = StCommit;
                    end
                end
            end
            StCommit: begin
                if (cnt_q == last_q) begin
                    state_d = StResult;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StResult: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Outputs are registered from next-state values so the write for entry i
    // appears in the same cycle the FSM sits in COMMIT with index i.
    always_comb begin
        addr_sum   = {1'b0, start_q} + {1'b0, cnt_d};
        wr_en_d    = (state_d == StCommit);
        wr_sel_d   = wr_en_d ? sel_q : 2'b00;
        wr_addr_d  = 4'h0;
        wr_data_d  = 4'h0;
        if (wr_en_d) begin
            wr_addr_d = (sel_q == 2'b00) ? 4'(addr_sum % 5'(UCODE_DEPTH)) : addr_sum[3:0];
            wr_data_d = buf_q[cnt_d];
        end
        seq_hold_d = state_d inside {StAddr, StData, StCsum, StCommit};
        done_d     = (state_d == StResult) && !err_flag_d;
        err_d      = (state_d == StResult) && err_flag_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            sel_q      <= 2'b00;
            start_q    <= 4'h0;
            last_q     <= 4'h0;
            cnt_q      <= 4'h0;
            csum_q     <= 8'h00;
            err_flag_q <= 1'b0;
            wr_en      <= 1'b0;
            wr_sel     <= 2'b00;
            wr_addr    <= 4'h0;
            wr_data    <= 4'h0;
            seq_hold   <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            start_q    <= start_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            csum_q     <= csum_d;
            err_flag_q <= err_flag_d;
            wr_en      <= wr_en_d;
            wr_sel     <= wr_sel_d;
            wr_addr    <= wr_addr_d;
            wr_data    <= wr_data_d;
            seq_hold   <= seq_hold_d;
            done       <= done_d;
            err        <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_q[cnt_q] <= in_byte[3:0];
        end
    end

endmodule

// File: tb/tb_ucode_loader.sv
// Directed bench for ucode_loader: per-cycle monitor logs writes, pulses and
// handshake, and each scenario task checks the logs against hand-computed values.
module tb_ucode_loader;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_byte = 8'h00;
    logic       in_ready, wr_en, seq_hold, done, err;
    logic [1:0] wr_sel;
    logic [3:0] wr_addr, wr_data;

    ucode_loader dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_byte(in_byte),
        .in_ready(in_ready), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
        .wr_data(wr_data), .seq_hold(seq_hold), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int         cyc;
        logic [1:0] sel;
        logic [3:0] addr;
        logic [3:0] data;
    } wr_t;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   hdr_acc = 0;
    int   last_acc = 0;
    wr_t  wr_q[$];
    int   done_q[$];
    int   err_q[$];
    logic hold_log[4096];
    logic ready_log[4096];
    logic [7:0] pkt[$];

    function automatic wr_t mk_wr(int c, logic [1:0] s, logic [3:0] a, logic [3:0] d);
        wr_t w;
        w.cyc = c; w.sel = s; w.addr = a; w.data = d;
        return w;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Sample a half cycle after the edge; index = number of edges seen so far.
    always @(negedge clk) begin
        if (wr_en) wr_q.push_back(mk_wr(cyc, wr_sel, wr_addr, wr_data));
        if (done) done_q.push_back(cyc);
        if (err) err_q.push_back(cyc);
        if (cyc < 4096) begin
            hold_log[cyc]  <= seq_hold;
            ready_log[cyc] <= in_ready;
        end
    end

    task automatic clear_logs();
        wr_q.delete();
        done_q.delete();
        err_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        @(negedge clk);
        in_valid = 1'b1;
        in_byte  = b;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            total++; bad++;
            $display("FAIL accept_timeout: byte %h in_ready=%b, required 1", b, in_ready);
        end else begin
            @(posedge clk);
            #1 last_acc = cyc;
        end
    endtask

    task automatic send_pkt();
        foreach (pkt[i]) begin
            send_byte(pkt[i]);
            if (i == 0) hdr_acc = last_acc;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++; $display("FAIL reset_ready_low: in_ready=%b, required 0", in_ready);
        end
        total++;
        if ({wr_en, wr_sel, wr_addr, wr_data, seq_hold, done, err} !== 15'h0) begin
            bad++;
            $display("FAIL reset_outputs: got %h, required 0",
                     {wr_en, wr_sel, wr_addr, wr_data, seq_hold, done, err});
        end
        reset = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_ready_high: in_ready=%b, required 1", in_ready);
        end
    endtask

    task automatic test_ucode_wrap();
        logic [3:0] ea [3] = '{4'hE, 4'hF, 4'h0};
        logic [3:0] ed [3] = '{4'h1, 4'h2, 4'h4};
        int c;
        clear_logs();
        pkt = '{8'h02, 8'h0E, 8'h01, 8'h02, 8'h04, 8'h0B};
        send_pkt();
        c = last_acc;
        repeat (6) @(negedge clk);
        total++;
        if (wr_q.size() != 3) begin
            bad++; $display("FAIL wrap_count: writes=%0d, required 3", wr_q.size());
        end
        for (int i = 0; i < 3 && i < wr_q.size(); i++) begin
            total++;
            if (wr_q[i] !== mk_wr(c + i, 2'b00, ea[i], ed[i])) begin
                bad++;
                $display("FAIL wrap_wr%0d: cyc=%0d sel=%b addr=%h data=%h, required cyc=%0d sel=00 addr=%h data=%h",
                         i, wr_q[i].cyc, wr_q[i].sel, wr_q[i].addr, wr_q[i].data, c + i, ea[i], ed[i]);
            end
        end
        total++;
        if (done_q.size() != 1 || done_q[0] != c + 3 || err_q.size() != 0) begin
            bad++;
            $display("FAIL wrap_done: done_pulses=%0d err_pulses=%0d, required one done at cyc %0d",
                     done_q.size(), err_q.size(), c + 3);
        end
        for (int k = hdr_acc; k <= c + 3; k++) begin
            total++;
            if (hold_log[k] !== (k <= c + 2)) begin
                bad++;
                $display("FAIL wrap_hold: cyc=%0d seq_hold=%b, required %b", k, hold_log[k], k <= c + 2);
            end
        end
    endtask

    task automatic test_disp_full();
        logic [3:0] ed [4] = '{4'hB, 4'hC, 4'hC, 4'hC};
        int c;
        clear_logs();
        pkt = '{8'h83, 8'h00, 8'h0B, 8'h0C, 8'h0C, 8'h0C, 8'h84};
        send_pkt();
        c = last_acc;
        repeat (7) @(negedge clk);
        total++;
        if (wr_q.size() != 4) begin
            bad++; $display("FAIL disp_count: writes=%0d, required 4", wr_q.size());
        end
        for (int i = 0; i < 4 && i < wr_q.size(); i++) begin
            total++;
            if (wr_q[i] !== mk_wr(c + i, 2'b10, 4'(i), ed[i])) begin
                bad++;
                $display("FAIL disp_wr%0d: cyc=%0d sel=%b addr=%h data=%h, required cyc=%0d sel=10 addr=%0d data=%h",
                         i, wr_q[i].cyc, wr_q[i].sel, wr_q[i].addr, wr_q[i].data, c + i, i, ed[i]);
            end
        end
        total++;
        if (done_q.size() != 1 || done_q[0] != c + 4 || err_q.size() != 0) begin
            bad++;
            $display("FAIL disp_done: done_pulses=%0d err_pulses=%0d, required one done at cyc %0d",
                     done_q.size(), err_q.size(), c + 4);
        end
    endtask

    task automatic test_bad_csum();
        int c;
        clear_logs();
        pkt = '{8'h02, 8'h0E, 8'h01, 8'h02, 8'h04, 8'h0A};
        send_pkt();
        c = last_acc;
        repeat (6) @(negedge clk);
        total++;
        if (wr_q.size() != 0 || done_q.size() != 0) begin
            bad++;
            $display("FAIL csum_nowrite: writes=%0d done_pulses=%0d, required 0 and 0",
                     wr_q.size(), done_q.size());
        end
        total++;
        if (err_q.size() != 1 || err_q[0] != c) begin
            bad++; $display("FAIL csum_err: err_pulses=%0d, required one at cyc %0d", err_q.size(), c);
        end
        total++;
        if (hold_log[c - 1] !== 1'b1 || hold_log[c] !== 1'b0) begin
            bad++;
            $display("FAIL csum_hold: seq_hold=%b,%b at csum/err cycles, required 1,0",
                     hold_log[c - 1], hold_log[c]);
        end
    endtask

    task automatic test_disp_overflow();
        int c;
        clear_logs();
        pkt = '{8'h41, 8'h03, 8'h04, 8'h05, 8'h43};
        send_pkt();
        c = last_acc;
        pkt = '{8'h02, 8'h0E, 8'h01, 8'h02, 8'h04, 8'h0B};
        send_pkt();
        repeat (6) @(negedge clk);
        total++;
        if (err_q.size() != 1 || err_q[0] != c) begin
            bad++; $display("FAIL ovf_err: err_pulses=%0d, required one at cyc %0d", err_q.size(), c);
        end
        total++;
        if (wr_q.size() != 3 || done_q.size() != 1) begin
            bad++;
            $display("FAIL ovf_follow: writes=%0d done_pulses=%0d, required 3 and 1",
                     wr_q.size(), done_q.size());
        end else begin
            total++;
            if (wr_q[0].sel !== 2'b00 || wr_q[0].addr !== 4'hE || wr_q[2].addr !== 4'h0 ||
                wr_q[2].data !== 4'h4) begin
                bad++;
                $display("FAIL ovf_follow_data: first=(%b,%h,%h) last=(%b,%h,%h), required (00,E,1) (00,0,4)",
                         wr_q[0].sel, wr_q[0].addr, wr_q[0].data,
                         wr_q[2].sel, wr_q[2].addr, wr_q[2].data);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] es [5] = '{2'b10, 2'b10, 2'b00, 2'b00, 2'b00};
        logic [3:0] ea [5] = '{4'h1, 4'h2, 4'hE, 4'hF, 4'h0};
        logic [3:0] ed [5] = '{4'h7, 4'h9, 4'h1, 4'h2, 4'h4};
        int a, c, nh;
        clear_logs();
        send_byte(8'h81);
        send_byte(8'h01);
        send_byte(8'h07);
        a = last_acc;
        @(negedge clk);
        in_valid = 1'b0;
        in_byte  = 8'hFF;
        repeat (3) @(posedge clk);
        send_byte(8'h09);
        total++;
        if (last_acc != a + 4) begin
            bad++; $display("FAIL gap_accept: data byte accepted at cyc %0d, required %0d", last_acc, a + 4);
        end
        for (int k = a; k <= a + 3; k++) begin
            total++;
            if (ready_log[k] !== 1'b1 || hold_log[k] !== 1'b1) begin
                bad++;
                $display("FAIL gap_hold: cyc=%0d in_ready=%b seq_hold=%b, required 1,1",
                         k, ready_log[k], hold_log[k]);
            end
        end
        send_byte(8'h8E);
        c = last_acc;
        send_byte(8'h02);
        nh = last_acc;
        pkt = '{8'h0E, 8'h01, 8'h02, 8'h04, 8'h0B};
        send_pkt();
        repeat (6) @(negedge clk);
        total++;
        if (nh != c + 4) begin
            bad++; $display("FAIL b2b_hdr: next header accepted at cyc %0d, required %0d", nh, c + 4);
        end
        for (int k = c; k <= c + 2; k++) begin
            total++;
            if (ready_log[k] !== 1'b0) begin
                bad++; $display("FAIL b2b_ready: cyc=%0d in_ready=%b, required 0", k, ready_log[k]);
            end
        end
        total++;
        if (wr_q.size() != 5 || done_q.size() != 2 || err_q.size() != 0 || done_q[0] != c + 2) begin
            bad++;
            $display("FAIL b2b_count: writes=%0d done_pulses=%0d err_pulses=%0d, required 5,2,0 first done cyc %0d",
                     wr_q.size(), done_q.size(), err_q.size(), c + 2);
        end
        for (int i = 0; i < 5 && i < wr_q.size(); i++) begin
            total++;
            if (wr_q[i].sel !== es[i] || wr_q[i].addr !== ea[i] || wr_q[i].data !== ed[i]) begin
                bad++;
                $display("FAIL b2b_wr%0d: sel=%b addr=%h data=%h, required sel=%b addr=%h data=%h",
                         i, wr_q[i].sel, wr_q[i].addr, wr_q[i].data, es[i], ea[i], ed[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_logs();
        send_byte(8'h02);
        send_byte(8'h0E);
        send_byte(8'h01);
        send_byte(8'h02);
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++; $display("FAIL rst_mid_ready_low: in_ready=%b, required 0", in_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++;
        if ({wr_en, wr_sel, wr_addr, wr_data, seq_hold, done, err, in_ready} !== 16'h0001) begin
            bad++;
            $display("FAIL rst_mid_outputs: got %h, required 0001",
                     {wr_en, wr_sel, wr_addr, wr_data, seq_hold, done, err, in_ready});
        end
        repeat (8) @(negedge clk);
        total++;
        if (wr_q.size() != 0 || done_q.size() != 0 || err_q.size() != 0) begin
            bad++;
            $display("FAIL rst_mid_quiet: writes=%0d done=%0d err=%0d, required 0,0,0",
                     wr_q.size(), done_q.size(), err_q.size());
        end
        pkt = '{8'h02, 8'h0E, 8'h01, 8'h02, 8'h04, 8'h0B};
        send_pkt();
        repeat (6) @(negedge clk);
        total++;
        if (wr_q.size() != 3 || done_q.size() != 1 || err_q.size() != 0) begin
            bad++;
            $display("FAIL rst_mid_reload: writes=%0d done=%0d err=%0d, required 3,1,0",
                     wr_q.size(), done_q.size(), err_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_ucode_wrap();
        test_disp_full();
        test_bad_csum();
        test_disp_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
